// File: rtl/o_buf_pkg.sv
// rtl/o_buf_pkg.sv - shared constants and drain state type for the output-buffer drain engine
// Contents:
//   ARRAY_M, OUT_WIDTH, RAM_SIZE, ADDR_WIDTH, COL_IDX_WIDTH - buffer geometry
//   drain_state_e - IDLE / ISSUE / DRAIN / DONE
package o_buf_pkg;

    localparam int ARRAY_M       = 8;
    localparam int OUT_WIDTH     = 32;
    localparam int RAM_SIZE      = 256;
    localparam int ADDR_WIDTH    = $clog2(RAM_SIZE);
    localparam int COL_IDX_WIDTH = $clog2(ARRAY_M);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/o_drain_fifo.sv
// rtl/o_drain_fifo.sv - synchronous FIFO holding read data between the buffer and the output stream
// Ports:
//   clk, reset     - clock, asynchronous active-low reset (clears storage, pointers, count)
//   push/push_data - write one entry; ignored when full unless a pop happens in the same cycle
//   pop            - remove the head entry; ignored when empty
//   head           - current head entry
//   count          - number of valid entries (0..DEPTH)
module o_drain_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign rd_ok = pop && (count != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_ok = push && ((count != CNT_W'(DEPTH)) || rd_ok);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/o_buf_drain.sv
// rtl/o_buf_drain.sv - read-side drain engine streaming a rectangular output-buffer region column-major
// Optional build macro: O_DRAIN_LAST_EN adds m_last (final beat of each column) and m_last_all (final beat of drain).
// Ports:
//   clk, reset                        - clock, asynchronous active-low reset
//   start, base_addr, num_rows, num_cols - launch a drain (sampled in IDLE only)
//   busy, done                        - drain in progress / one-cycle completion pulse
//   ram_idx, read_addr, data_read     - buffer read port (data RD_LAT cycles after address)
//   m_data, m_valid, m_ready          - output stream
module o_buf_drain
    import o_buf_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [ADDR_WIDTH:0]      num_rows,
    input  logic [COL_IDX_WIDTH:0]   num_cols,
    output logic                     busy,
    output logic                     done,
    output logic [COL_IDX_WIDTH-1:0] ram_idx,
    output logic [ADDR_WIDTH-1:0]    read_addr,
    input  logic [OUT_WIDTH-1:0]     data_read,
    output logic [OUT_WIDTH-1:0]     m_data,
    output logic                     m_valid,
    input  logic                     m_ready
`ifdef O_DRAIN_LAST_EN
    ,
    output logic                     m_last,
    output logic                     m_last_all
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ROW_W = ADDR_WIDTH + 1;
    localparam int COL_W = COL_IDX_WIDTH + 1;
`ifdef O_DRAIN_LAST_EN
    localparam int FIFO_W = OUT_WIDTH + 2;
`else
    localparam int FIFO_W = OUT_WIDTH;
`endif
    localparam logic [COL_W-1:0] COLS_MAX = COL_W'(ARRAY_M);

    drain_state_e state, state_next;

    logic [ADDR_WIDTH-1:0]    base_q, cur_addr, last_addr_q;
    logic [ROW_W-1:0]         rows_q, row_cnt;
    logic [COL_W-1:0]         cols_q, cols_clamped;
    logic [COL_IDX_WIDTH-1:0] col_cnt, last_col_q;
    logic [RD_LAT-1:0]        tag_q, tag_next;
    logic [CNT_W-1:0]         inflight, fifo_count;
    logic                     credit_ok, issue, row_end, col_end, push, pop;
    logic [FIFO_W-1:0]        push_data, head;

    assign cols_clamped = (num_cols > COLS_MAX) ? COLS_MAX : num_cols;
    assign cur_addr     = base_q + row_cnt[ADDR_WIDTH-1:0];
    assign row_end      = (row_cnt == rows_q - ROW_W'(1));
    assign col_end      = ({1'b0, col_cnt} == cols_q - COL_W'(1));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(tag_q[i]);
        end
    end

    // Every issued read already owns a FIFO slot, so pushes can never overflow.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_rows == '0 || cols_clamped == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                issue = credit_ok;
                if (credit_ok && row_end && col_end) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the final word is accepted so done lands right after the last beat.
                if (inflight == '0 && (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        tag_next    = tag_q << 1;
        tag_next[0] = issue;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            base_q      <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            row_cnt     <= '0;
            col_cnt     <= '0;
            last_addr_q <= '0;
            last_col_q  <= '0;
            tag_q       <= '0;
        end else begin
            state <= state_next;
            tag_q <= tag_next;
            if (state == IDLE && start) begin
                base_q  <= base_addr;
                rows_q  <= num_rows;
                cols_q  <= cols_clamped;
                row_cnt <= '0;
                col_cnt <= '0;
            end
            if (issue) begin
                last_addr_q <= cur_addr;
                last_col_q  <= col_cnt;
                if (row_end) begin
                    row_cnt <= '0;
                    col_cnt <= col_cnt + COL_IDX_WIDTH'(1);
                end else begin
                    row_cnt <= row_cnt + ROW_W'(1);
                end
            end
        end
    end

    // The port shows the address being issued; between issues it keeps the last one.
    assign read_addr = issue ? cur_addr : last_addr_q;
    assign ram_idx   = issue ? col_cnt  : last_col_q;
    assign busy      = (state == ISSUE) || (state == DRAIN);
    assign done      = (state == DONE);

    assign push    = tag_q[RD_LAT-1];
    assign m_valid = (fifo_count != '0);
    assign pop     = m_valid && m_ready;

`ifdef O_DRAIN_LAST_EN
    logic [RD_LAT-1:0] lcol_q, lcol_next, lall_q, lall_next;

    always_comb begin
        lcol_next    = lcol_q << 1;
        lcol_next[0] = issue && row_end;
        lall_next    = lall_q << 1;
        lall_next[0] = issue && row_end && col_end;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lcol_q <= '0;
            lall_q <= '0;
        end else begin
            lcol_q <= lcol_next;
            lall_q <= lall_next;
        end
    end

    assign push_data  = {lcol_q[RD_LAT-1], lall_q[RD_LAT-1], data_read};
    assign m_last     = head[FIFO_W-1];
    assign m_last_all = head[FIFO_W-2];
    assign m_data     = head[OUT_WIDTH-1:0];
`else
    assign push_data = data_read;
    assign m_data    = head;
`endif

    o_drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_o_buf_drain.sv
// tb/tb_o_buf_drain.sv - scoreboard bench for o_buf_drain with a latency-1 buffer model
module tb_o_buf_drain;
    import o_buf_pkg::*;

    localparam int PAIR_W = COL_IDX_WIDTH + ADDR_WIDTH;
    localparam int DEPTH  = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [ADDR_WIDTH-1:0]    base_addr;
    logic [ADDR_WIDTH:0]      num_rows;
    logic [COL_IDX_WIDTH:0]   num_cols;
    logic                     busy, done;
    logic [COL_IDX_WIDTH-1:0] ram_idx;
    logic [ADDR_WIDTH-1:0]    read_addr;
    logic [OUT_WIDTH-1:0]     data_read;
    logic [OUT_WIDTH-1:0]     m_data;
    logic                     m_valid;
    logic                     m_ready;
`ifdef O_DRAIN_LAST_EN
    logic                     m_last, m_last_all;
`endif

    always #5 clk = ~clk;

    o_buf_drain dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .num_cols  (num_cols),
        .busy      (busy),
        .done      (done),
        .ram_idx   (ram_idx),
        .read_addr (read_addr),
        .data_read (data_read),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
`ifdef O_DRAIN_LAST_EN
        ,
        .m_last    (m_last),
        .m_last_all(m_last_all)
`endif
    );

    function automatic logic [31:0] word_at(int col, int addr);
        if (addr >= 16 && addr < 24) return 32'(8 * (addr - 16) + col);
        return 32'hA000_0000 | 32'(col << 8) | 32'(addr);
    endfunction

    logic [OUT_WIDTH-1:0] mem [ARRAY_M][RAM_SIZE];
    initial begin
        for (int c = 0; c < ARRAY_M; c++)
            for (int a = 0; a < RAM_SIZE; a++)
                mem[c][a] = word_at(c, a);
    end
    always @(posedge clk) data_read <= mem[ram_idx][read_addr];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, last_beat_cyc = 0, first_beat_cyc = -1, start_cyc = 0;
    int run_beats = 0, run_issues = 0, max_occ = 0, exp_beats = 0, bp_cyc = 0;
    bit valid_seen = 0, stall_prev = 0, bp_mode = 0;
    logic [OUT_WIDTH-1:0] prev_data = '0;
    logic [PAIR_W-1:0] prev_pair = '0;
    logic [33:0] exp_q [$];
    logic [PAIR_W-1:0] addr_log [$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_region(int base, int rows, int cols);
        int nc;
        nc = (cols > ARRAY_M) ? ARRAY_M : cols;
        for (int c = 0; c < nc; c++)
            for (int r = 0; r < rows; r++)
                exp_q.push_back({(r == rows - 1), (r == rows - 1 && c == nc - 1),
                                 word_at(c, (base + r) % RAM_SIZE)});
        exp_beats = rows * nc;
    endtask

    // One clock: observe at the falling edge, then drive m_ready just after the rising edge.
    task automatic tick();
        logic [33:0] e;
        logic [PAIR_W-1:0] pair;
        int occ;
        @(negedge clk);
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (reset) begin
            if (stall_prev) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_data", 64'(m_data), 64'(prev_data));
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid) valid_seen = 1;
            pair = {ram_idx, read_addr};
            if (busy && pair != prev_pair) begin
                run_issues++;
                addr_log.push_back(pair);
            end
            prev_pair = pair;
            if (m_valid && m_ready) begin
                run_beats++;
                last_beat_cyc = cyc;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(m_data), 64'(e[31:0]));
`ifdef O_DRAIN_LAST_EN
                    check("beat_last", 64'(m_last), 64'(e[33]));
                    check("beat_last_all", 64'(m_last_all), 64'(e[32]));
`endif
                end
            end
            occ = run_issues - run_beats;
            if (occ > max_occ) max_occ = occ;
        end else begin
            stall_prev = 0;
        end
        @(posedge clk);
        #1;
        if (bp_mode) begin
            bp_cyc++;
            m_ready = (bp_cyc >= 30 && bp_cyc < 40) ? 1'b0 : 1'($urandom_range(0, 1));
        end else begin
            m_ready = 1'b1;
        end
    endtask

    task automatic launch(int base, int rows, int cols);
        push_region(base, rows, cols);
        run_beats = 0;
        run_issues = 0;
        max_occ = 0;
        valid_seen = 0;
        first_beat_cyc = -1;
        base_addr = ADDR_WIDTH'(base);
        num_rows = (ADDR_WIDTH + 1)'(rows);
        num_cols = (COL_IDX_WIDTH + 1)'(cols);
        start = 1'b1;
        tick();
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic run_drain(string tag, int base, int rows, int cols, int restart_at);
        int d0, n;
        bit restarted;
        d0 = done_cnt;
        restarted = 0;
        launch(base, rows, cols);
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            if (restart_at >= 0 && run_beats == restart_at && !restarted) begin
                start = 1'b1;
                base_addr = '0;
                restarted = 1;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
        if (exp_beats > 0) begin
            check({tag, "_done_after_last"}, 64'(done_cyc - last_beat_cyc), 64'd1);
            if (!bp_mode)
                check({tag, "_first_valid"}, 64'(first_beat_cyc - start_cyc), 64'd3);
        end else begin
            check({tag, "_done_latency"}, 64'(done_cyc - start_cyc), 64'd1);
            check({tag, "_no_valid"}, 64'(valid_seen), 64'd0);
        end
        repeat (3) tick();
        check({tag, "_single_done"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_beats"}, 64'(run_beats), 64'(exp_beats));
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int d0, n;
        reset = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_rows = '0;
        num_cols = '0;
        m_ready = 1'b1;
        repeat (2) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_data", 64'(m_data), 64'd0);
        check("rst_ram_idx", 64'(ram_idx), 64'd0);
        check("rst_read_addr", 64'(read_addr), 64'd0);
        reset = 1'b1;
        tick();

        run_drain("full", 16, 8, 8, -1);

        bp_mode = 1;
        bp_cyc = 0;
        run_drain("bp", 16, 8, 8, -1);
        check("bp_occupancy", 64'(max_occ <= DEPTH), 64'd1);
        bp_mode = 0;

        addr_log.delete();
        run_drain("wrap", 250, 8, 1, -1);
        check("wrap_addr_count", 64'(addr_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < addr_log.size(); k++)
            check("wrap_addr", 64'(addr_log[k]), 64'({COL_IDX_WIDTH'(0), ADDR_WIDTH'((250 + k) % RAM_SIZE)}));

        run_drain("zero_rows", 16, 0, 8, -1);
        run_drain("zero_cols", 16, 8, 0, -1);
        run_drain("clamp", 16, 2, 9, -1);
        run_drain("restart", 16, 8, 8, 10);

        launch(16, 8, 8);
        n = 0;
        while (run_beats < 20 && n < 500) begin
            tick();
            n++;
        end
        check("rst_mid_reached", 64'(run_beats), 64'd20);
        reset = 1'b0;
        #1;
        check("rst_mid_valid", 64'(m_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) tick();
        check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        reset = 1'b1;
        tick();
        run_drain("after_rst", 16, 8, 8, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
